// File: rtl/fetch_unit_if.sv
// Decode-side and instruction-memory signals of the fetch unit.
// The master modport is the fetch unit; the slave side is decode plus instruction memory.
interface fetch_unit_if;
    logic        Stall;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        Halt;
    logic        IMemEn;
    logic [15:0] IMemAddr;
    logic [15:0] IMemData;
    logic        IMemDone;
    logic [15:0] Instruct;
    logic [15:0] PCInc;
    logic        InstrValid;
    logic        Halted;
    logic        err;

    modport master (
        input  Stall, Redirect, RedirectPC, Halt, IMemData, IMemDone,
        output IMemEn, IMemAddr, Instruct, PCInc, InstrValid, Halted, err
    );

    modport slave (
        output Stall, Redirect, RedirectPC, Halt, IMemData, IMemDone,
        input  IMemEn, IMemAddr, Instruct, PCInc, InstrValid, Halted, err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding IMem request, decode stall/redirect/halt handling.
// Define FETCH_ALIGN_CHECK_EN to trap odd fetch addresses (err + halt) instead of masking PC[0].
module fetch_unit (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam logic [1:0] StFetch  = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;
    localparam logic [1:0] StHalted = 2'd3;
    localparam logic [15:0] Nop     = 16'h0800;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcinc_q, pcinc_d;
    logic        valid_q, valid_d;
    logic        stale_q, stale_d;
    logic        err_q, err_d;
    logic        misalign;
    logic [15:0] redirect_pc;
    logic        front;
    logic        blocked;
    logic        req_go;
    logic        imem_en;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign    = pc_q[0];
    assign redirect_pc = bus.RedirectPC;
`else
    assign misalign    = 1'b0;
    assign redirect_pc = {bus.RedirectPC[15:1], 1'b0};
`endif

    // HOLD behaves like FETCH once Stall drops, so the request goes out in the Stall-fall cycle.
    assign front   = (state_q == StFetch) || (state_q == StHold);
    assign blocked = valid_q && (bus.Stall || bus.Halt);
    assign req_go  = front && !bus.Redirect && !blocked && !misalign;
    assign imem_en = req_go && rst;

    assign bus.IMemEn     = imem_en;
    assign bus.IMemAddr   = imem_en ? pc_q : 16'h0000;
    assign bus.Instruct   = valid_q ? instr_q : Nop;
    assign bus.PCInc      = pcinc_q;
    assign bus.InstrValid = valid_q;
    assign bus.Halted     = (state_q == StHalted);
    assign bus.err        = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcinc_d = pcinc_q;
        valid_d = valid_q;
        stale_d = stale_q;
        err_d   = err_q;

        // A response is legal only in the request cycle itself or while waiting for one.
        if (bus.IMemDone && !(req_go || (state_q == StWait))) begin
            err_d = 1'b1;
        end

        case (state_q)
            StFetch, StHold: begin
                if (bus.Redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end else if (valid_q && bus.Stall) begin
                    state_d = StHold;
                end else if (valid_q && bus.Halt) begin
                    valid_d = 1'b0;
                    state_d = StHalted;
                end else if (misalign) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = StHalted;
                end else if (bus.IMemDone) begin
                    instr_d = bus.IMemData;
                    pcinc_d = pc_q + 16'd2;
                    pc_d    = pc_q + 16'd2;
                    valid_d = 1'b1;
                    state_d = StFetch;
                end else begin
                    valid_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.IMemDone) begin
                    state_d = StFetch;
                    stale_d = 1'b0;
                    if (!stale_q && !bus.Redirect) begin
                        instr_d = bus.IMemData;
                        pcinc_d = pc_q + 16'd2;
                        pc_d    = pc_q + 16'd2;
                        valid_d = 1'b1;
                    end
                end else if (bus.Redirect) begin
                    stale_d = 1'b1;
                end
                if (bus.Redirect) begin
                    pc_d = redirect_pc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            pc_q    <= 16'h0000;
            instr_q <= Nop;
            pcinc_q <= 16'h0000;
            valid_q <= 1'b0;
            stale_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcinc_q <= pcinc_d;
            valid_q <= valid_d;
            stale_q <= stale_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-stepped memory model with an address queue
// and a scoreboard of expected {Instruct, PCInc} words popped as decode sees new instructions.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] addr_q[$];
    logic [31:0] data_q[$];
    int          lat         = 1;
    bit          pend        = 1'b0;
    bit          pend_stale  = 1'b0;
    int          pend_cnt    = 0;
    logic [15:0] pend_addr   = 16'h0000;
    bit          prev_hold   = 1'b0;
    int          new_cnt     = 0;
    logic        cyc_en      = 1'b0;
    logic [15:0] cyc_addr    = 16'h0000;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        case (a)
            16'h0000: memfn = 16'h1111;
            16'h0002: memfn = 16'h2222;
            16'h0100: memfn = 16'hA5A5;
            16'h0200: memfn = 16'h0000;
            default:  memfn = {a[7:0] ^ 8'hC3, a[7:0]};
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = 16'h0000; bus.Halt = 1'b0;
        bus.IMemDone = 1'b0; bus.IMemData = 16'h0000;
        pend = 1'b0; pend_stale = 1'b0; prev_hold = 1'b0; new_cnt = 0;
        addr_q.delete();
        data_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic tick(input bit s, input bit r, input logic [15:0] rpc, input bit h,
                        input bit spur);
        logic [31:0] got;
        logic [31:0] exp;
        logic [15:0] ea;
        if (bus.InstrValid === 1'b1 && !prev_hold) begin
            new_cnt++;
            vectors++;
            got = {bus.Instruct, bus.PCInc};
            if (data_q.size() == 0) begin
                miscompares++;
                $display("FAIL decode_word: got %h, no instruction expected", got);
            end else begin
                exp = data_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL decode_word: got %h, want %h", got, exp);
                end
            end
        end
        bus.Stall = s; bus.Redirect = r; bus.RedirectPC = rpc; bus.Halt = h;
        bus.IMemDone = 1'b0; bus.IMemData = 16'h0000;
        prev_hold = (bus.InstrValid === 1'b1) && s && !r;
        #1;
        cyc_en   = bus.IMemEn;
        cyc_addr = bus.IMemAddr;
        if (pend) begin
            if (r) pend_stale = 1'b1;
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.IMemDone = 1'b1;
                bus.IMemData = memfn(pend_addr);
                if (!pend_stale) data_q.push_back({memfn(pend_addr), pend_addr + 16'd2});
                pend = 1'b0;
            end
        end
        if (bus.IMemEn === 1'b1) begin
            vectors++;
            if (addr_q.size() == 0) begin
                miscompares++;
                $display("FAIL imem_addr: got request to %h, none expected", bus.IMemAddr);
            end else begin
                ea = addr_q.pop_front();
                if (bus.IMemAddr !== ea) begin
                    miscompares++;
                    $display("FAIL imem_addr: got %h, want %h", bus.IMemAddr, ea);
                end
                if (lat == 1) begin
                    bus.IMemDone = 1'b1;
                    bus.IMemData = memfn(ea);
                    data_q.push_back({memfn(ea), ea + 16'd2});
                end else begin
                    pend = 1'b1; pend_stale = 1'b0; pend_cnt = lat - 1; pend_addr = ea;
                end
            end
        end
        if (spur) bus.IMemDone = 1'b1;
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = 16'h0000; bus.Halt = 1'b0;
        bus.IMemDone = 1'b0; bus.IMemData = 16'h0000;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({bus.IMemEn, bus.IMemAddr, bus.InstrValid, bus.Halted, bus.err} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got en=%b addr=%h v=%b h=%b e=%b, want all 0",
                     bus.IMemEn, bus.IMemAddr, bus.InstrValid, bus.Halted, bus.err);
        end
        vectors++;
        if ({bus.Instruct, bus.PCInc} !== 32'h0800_0000) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h, want 0800/0000", bus.Instruct, bus.PCInc);
        end
        do_reset();
    endtask

    task automatic test_single_cycle();
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) addr_q.push_back(16'(2 * i));
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            vectors++;
            if (cyc_en !== 1'b1) begin
                miscompares++;
                $display("FAIL single_en cycle %0d: got %b, want 1", k, cyc_en);
            end
            if (k <= 2) begin
                vectors++;
                if ({bus.Instruct, bus.PCInc} !== ((k == 1) ? 32'h1111_0002 : 32'h2222_0004))
                begin
                    miscompares++;
                    $display("FAIL single_word %0d: got %h/%h", k, bus.Instruct, bus.PCInc);
                end
            end
        end
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (new_cnt !== 6 || data_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_count: got %0d instructions, want 6", new_cnt);
        end
    endtask

    task automatic test_latency3();
        do_reset();
        lat = 3;
        addr_q.push_back(16'h0000); addr_q.push_back(16'h0002); addr_q.push_back(16'h0004);
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            vectors++;
            if (cyc_en !== ((k % 3) == 1) || bus.InstrValid !== ((k % 3) == 0)) begin
                miscompares++;
                $display("FAIL lat3_pattern cycle %0d: got en=%b valid=%b", k, cyc_en,
                         bus.InstrValid);
            end
        end
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (new_cnt !== 3 || bus.err !== 1'b0 || data_q.size() != 0) begin
            miscompares++;
            $display("FAIL lat3_end: got count=%0d err=%b, want 3/0", new_cnt, bus.err);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1;
        addr_q.push_back(16'h0100); addr_q.push_back(16'h0102);
        tick(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            vectors++;
            if ({cyc_en, bus.Instruct, bus.PCInc, bus.InstrValid} !== {1'b0, 32'hA5A5_0102, 1'b1})
            begin
                miscompares++;
                $display("FAIL stall_freeze %0d: got en=%b %h/%h v=%b", k, cyc_en,
                         bus.Instruct, bus.PCInc, bus.InstrValid);
            end
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (cyc_en !== 1'b1 || cyc_addr !== 16'h0102) begin
            miscompares++;
            $display("FAIL stall_release: got en=%b addr=%h, want 1/0102", cyc_en, cyc_addr);
        end
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (data_q.size() != 0 || addr_q.size() != 0 || new_cnt !== 2) begin
            miscompares++;
            $display("FAIL stall_count: got %0d instructions, want 2", new_cnt);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        lat = 3;
        addr_q.push_back(16'h0000); addr_q.push_back(16'h0040);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (bus.InstrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_stale: got valid=%b, want 0", bus.InstrValid);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (cyc_en !== 1'b1 || cyc_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL redir_addr: got en=%b addr=%h, want 1/0040", cyc_en, cyc_addr);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (new_cnt !== 1 || bus.err !== 1'b0 || data_q.size() != 0) begin
            miscompares++;
            $display("FAIL redir_end: got count=%0d err=%b, want 1/0", new_cnt, bus.err);
        end
    endtask

    task automatic test_halt();
        do_reset();
        lat = 1;
        addr_q.push_back(16'h0200);
        tick(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if ({cyc_en, bus.Halted, bus.InstrValid, bus.Instruct} !== {3'b010, 16'h0800}) begin
            miscompares++;
            $display("FAIL halt_enter: got en=%b h=%b v=%b %h, want 0/1/0/0800", cyc_en,
                     bus.Halted, bus.InstrValid, bus.Instruct);
        end
        tick(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
        vectors++;
        if ({cyc_en, bus.Halted, bus.err} !== 3'b010) begin
            miscompares++;
            $display("FAIL halt_redirect: got en=%b h=%b e=%b, want 0/1/0", cyc_en,
                     bus.Halted, bus.err);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        vectors++;
        if ({cyc_en, bus.Halted, bus.err} !== 3'b011 || new_cnt !== 1) begin
            miscompares++;
            $display("FAIL halt_spurious: got en=%b h=%b e=%b, want 0/1/1", cyc_en,
                     bus.Halted, bus.err);
        end
    endtask

    task automatic test_wrap_align();
        do_reset();
        lat = 1;
        addr_q.push_back(16'hFFFE); addr_q.push_back(16'h0000);
        tick(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (bus.PCInc !== 16'h0000 || bus.InstrValid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_pcinc: got %h v=%b, want 0000/1", bus.PCInc, bus.InstrValid);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (cyc_en !== 1'b1 || cyc_addr !== 16'h0000 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_addr: got en=%b addr=%h err=%b", cyc_en, cyc_addr, bus.err);
        end
`ifndef FETCH_ALIGN_CHECK_EN
        addr_q.push_back(16'h0002);
`endif
        tick(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        vectors++;
        if ({cyc_en, bus.err, bus.Halted} !== 3'b011) begin
            miscompares++;
            $display("FAIL align_trap: got en=%b err=%b h=%b, want 0/1/1", cyc_en, bus.err,
                     bus.Halted);
        end
`else
        vectors++;
        if ({cyc_en, cyc_addr, bus.err, bus.Halted} !== {1'b1, 16'h0002, 2'b00}) begin
            miscompares++;
            $display("FAIL align_mask: got en=%b addr=%h err=%b h=%b, want 1/0002/0/0",
                     cyc_en, cyc_addr, bus.err, bus.Halted);
        end
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
`endif
        vectors++;
        if (data_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_end: got %0d words %0d addrs left, want 0/0", data_q.size(),
                     addr_q.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        lat = 3;
        addr_q.push_back(16'h0100);
        tick(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.IMemEn, bus.IMemAddr, bus.InstrValid, bus.Instruct} !== {18'h0, 16'h0800})
        begin
            miscompares++;
            $display("FAIL rst_wait: got en=%b addr=%h v=%b %h", bus.IMemEn, bus.IMemAddr,
                     bus.InstrValid, bus.Instruct);
        end
        do_reset();
        addr_q.push_back(16'h0000);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (cyc_en !== 1'b1 || cyc_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_first_addr: got en=%b addr=%h, want 1/0000", cyc_en, cyc_addr);
        end
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        vectors++;
        if (new_cnt !== 1 || data_q.size() != 0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resume: got count=%0d err=%b, want 1/0", new_cnt, bus.err);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_latency3();
        test_stall();
        test_redirect_wait();
        test_halt();
        test_wrap_align();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
